dev_bridge: RTL and testbench

//  CPU-side initiator for the memory-mapped device bus that the timers and other peripherals respond on.
//  - Accepts one word access at a time from the CPU data port.
//  - Decodes the address to one of NDEV device windows, then drives ADD/WE/DAT to the devices.
//  - Registers the selected device's read data and returns it with a one-cycle ready pulse.
//  - Synchronises device IRQ lines into the HWINT vector for CP0.

---
 rtl/dev_bridge_pkg.sv | 29 ++
 rtl/dev_addr_decode.sv | 26 ++
 rtl/dev_bridge.sv | 106 ++++++++++
 tb/tb_dev_bridge.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared definitions for the CPU-to-device bus bridge: FSM states, address map defaults,
// timer register offsets and the decoder result type.
package dev_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEV_BASE_DEF   = 32'h0000_7F00;
    localparam logic [31:0] DEV_STRIDE_DEF = 32'h0000_0010;

    // Word offsets of the timer registers inside a device window
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    typedef struct packed {
        logic       hit;
        logic       misaligned;
        logic [2:0] idx;
    } dec_t;

    function automatic logic dec_fault(input dec_t d);
        return !d.hit || d.misaligned;
    endfunction

endpackage

// File: rtl/dev_addr_decode.sv
// Combinational device-window decoder: byte address -> {hit, misaligned, window index}.
// Kept standalone so other bus initiators can share the same address map.
module dev_addr_decode
    import dev_bridge_pkg::*;
#(
    parameter int          NDEV       = 2,
    parameter logic [31:0] DEV_BASE   = DEV_BASE_DEF,
    parameter logic [31:0] DEV_STRIDE = DEV_STRIDE_DEF
) (
    input  logic [31:0] addr,
    output dec_t        dec
);

    logic [31:0] off;
    logic [31:0] widx;

    // NOTE: every variable of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        off            = addr - DEV_BASE;
        widx           = off / DEV_STRIDE;
        dec.hit        = (addr >= DEV_BASE) && (widx < NDEV);
        dec.misaligned = (addr[1:0] != 2'b00);
        dec.idx        = widx[2:0];
    end

endmodule

// File: rtl/dev_bridge.sv
// CPU-side initiator for the peripheral bus: one word access at a time in three cycles
// (IDLE accept, ACC strobe/capture, RESP ready), plus the registered HWINT vector for CP0.
module dev_bridge
    import dev_bridge_pkg::*;
#(
    parameter int          NDEV       = 2,
    parameter logic [31:0] DEV_BASE   = DEV_BASE_DEF,
    parameter logic [31:0] DEV_STRIDE = DEV_STRIDE_DEF
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_err,
    output logic [1:0]           DEV_ADD_O,
    output logic [31:0]          DEV_DAT_O,
    output logic [NDEV-1:0]      DEV_WE_O,
    input  logic [32*NDEV-1:0]   DEV_DAT_I,
    input  logic [NDEV-1:0]      DEV_IRQ_I,
    output logic [5:0]           HWINT
);

    state_t      state;
    logic        we_q;
    logic        fault_q;
    logic [2:0]  idx_q;
    dec_t        dec;
    logic [31:0] sel_rdata;
    logic [5:0]  irq_vec;

    dev_addr_decode #(
        .NDEV       (NDEV),
        .DEV_BASE   (DEV_BASE),
        .DEV_STRIDE (DEV_STRIDE)
    ) u_decode (
        .addr (cpu_addr),
        .dec  (dec)
    );

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (idx_q == 3'(i)) sel_rdata = DEV_DAT_I[32*i +: 32];
        end
    end

    always_comb begin
        irq_vec             = '0;
        irq_vec[NDEV-1:0]   = DEV_IRQ_I;
    end

    // Level passthrough with one flop of latency; deliberately unaware of the FSM
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) HWINT <= '0;
        else       HWINT <= irq_vec;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            idx_q     <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            DEV_ADD_O <= '0;
            DEV_DAT_O <= '0;
            DEV_WE_O  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_q      <= cpu_we;
                        fault_q   <= dec_fault(dec);
                        idx_q     <= dec.idx;
                        DEV_ADD_O <= cpu_addr[3:2];
                        DEV_DAT_O <= cpu_wdata;
                        // Strobe is registered here so it is high for exactly the ACC cycle
                        DEV_WE_O  <= (cpu_we && !dec_fault(dec)) ? (NDEV'(1) << dec.idx) : '0;
                        state     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    DEV_WE_O  <= '0;
                    cpu_rdata <= (we_q || fault_q) ? '0 : sel_rdata;
                    cpu_err   <= fault_q;
                    cpu_ready <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_bridge.sv
// Directed bench for dev_bridge: behavioural two-device model, scoreboard of expected
// responses, immediate-assertion checks and a single summary line.
module tb_dev_bridge;
    import dev_bridge_pkg::*;

    localparam int NDEV = 2;

    logic                CLK_I = 1'b0;
    logic                RST_I;
    logic                cpu_req;
    logic                cpu_we;
    logic [31:0]         cpu_addr;
    logic [31:0]         cpu_wdata;
    logic                cpu_ready;
    logic [31:0]         cpu_rdata;
    logic                cpu_err;
    logic [1:0]          DEV_ADD_O;
    logic [31:0]         DEV_DAT_O;
    logic [NDEV-1:0]     DEV_WE_O;
    logic [32*NDEV-1:0]  DEV_DAT_I;
    logic [NDEV-1:0]     DEV_IRQ_I;
    logic [5:0]          HWINT;

    dev_bridge #(.NDEV(NDEV)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .DEV_ADD_O (DEV_ADD_O),
        .DEV_DAT_O (DEV_DAT_O),
        .DEV_WE_O  (DEV_WE_O),
        .DEV_DAT_I (DEV_DAT_I),
        .DEV_IRQ_I (DEV_IRQ_I),
        .HWINT     (HWINT)
    );

    always #5 CLK_I = ~CLK_I;

    // Behavioural devices: four word registers each, reset to known contents
    logic [31:0] dev_mem [NDEV][4];

    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < NDEV; i++)
                for (int j = 0; j < 4; j++)
                    dev_mem[i][j] <= 32'h0;
            dev_mem[1][2] <= 32'hDEAD_BEEF;
            dev_mem[0][3] <= 32'hA5A5_0003;
        end else begin
            for (int i = 0; i < NDEV; i++)
                if (DEV_WE_O[i]) dev_mem[i][DEV_ADD_O] <= DEV_DAT_O;
        end
    end

    always_comb begin
        DEV_DAT_I = '0;
        for (int i = 0; i < NDEV; i++) DEV_DAT_I[32*i +: 32] = dev_mem[i][DEV_ADD_O];
    end

    int cyc_cnt = 0;
    always @(posedge CLK_I) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  last_we_add;
    logic [31:0] last_we_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. exp_lat counts the cycle the request is first presented as 1.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic [NDEV-1:0] exp_we,
                          input int exp_lat, input logic keep_req, output int ready_at);
        exp_t            e;
        int              cyc;
        int              we_cnt;
        logic [NDEV-1:0] we_seen;
        logic            done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cyc = 1; we_cnt = 0; we_seen = '0; done = 1'b0;
        while (!done && cyc < 12) begin
            @(negedge CLK_I);
            cyc++;
            if (DEV_WE_O != '0) begin
                we_cnt++;
                we_seen     = DEV_WE_O;
                last_we_add = DEV_ADD_O;
                last_we_dat = DEV_DAT_O;
            end
            if (cpu_ready) done = 1'b1;
        end
        ready_at = cyc_cnt;
        check({tag, ".ready_seen"}, 32'(done), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, ".we_pulses"}, 32'(we_cnt), (exp_we != '0) ? 32'd1 : 32'd0);
        check({tag, ".we_value"}, 32'(we_seen), 32'(exp_we));
        if (done) begin
            check({tag, ".sb_nonempty"}, 32'(sb_q.size()), 32'd1);
            e = sb_q.pop_front();
            check({tag, ".rdata"}, cpu_rdata, e.rdata);
            check({tag, ".err"}, 32'(cpu_err), 32'(e.err));
        end else begin
            sb_q.delete();
        end
        if (!keep_req) cpu_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".ready"}, 32'(cpu_ready), 32'd0);
        check({tag, ".rdata"}, cpu_rdata, 32'd0);
        check({tag, ".err"}, 32'(cpu_err), 32'd0);
        check({tag, ".add"}, 32'(DEV_ADD_O), 32'd0);
        check({tag, ".dat"}, DEV_DAT_O, 32'd0);
        check({tag, ".we"}, 32'(DEV_WE_O), 32'd0);
        check({tag, ".hwint"}, 32'(HWINT), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r1, r2, hits, first_hit, rdy_cnt;
        RST_I     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        DEV_IRQ_I = 2'b11;

        // Reset: every output low, IRQs ignored while held
        repeat (2) @(negedge CLK_I);
        check_outputs_zero("reset");
        DEV_IRQ_I = '0;
        RST_I     = 1'b0;
        @(negedge CLK_I);

        // 1: write timer PRESET of device 0 (0x7F04)
        access("t1_wr", 1'b1, DEV_BASE_DEF + 32'({TMR_PRESET, 2'b00}), 32'h0000_0064,
               32'h0, 1'b0, 2'b01, 3, 1'b0, r1);
        check("t1.we_add", 32'(last_we_add), 32'd1);
        check("t1.we_dat", last_we_dat, 32'h64);
        check("t1.add_held", 32'(DEV_ADD_O), 32'd1);
        check("t1.dat_held", DEV_DAT_O, 32'h64);
        @(negedge CLK_I);
        check("t1.ready_drop", 32'(cpu_ready), 32'd0);
        check("t1.dev_written", dev_mem[0][1], 32'h64);

        // 2: read device 1 COUNT (0x7F18)
        access("t2_rd", 1'b0, DEV_BASE_DEF + DEV_STRIDE_DEF + 32'({TMR_COUNT, 2'b00}), 32'h0,
               32'hDEAD_BEEF, 1'b0, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);
        check("t2.rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
        check("t2.err_idle", 32'(cpu_err), 32'd0);

        // 3: faults and window boundaries
        access("t3_beyond", 1'b0, 32'h0000_7F20, 32'h0, 32'h0, 1'b1, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);
        access("t3_misal", 1'b1, 32'h0000_7F02, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);
        access("t3_below", 1'b0, 32'h0000_7EFC, 32'h0, 32'h0, 1'b1, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);
        access("t3_word3", 1'b0, 32'h0000_7F0C, 32'h0, 32'hA5A5_0003, 1'b0, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);
        access("t3_last", 1'b0, 32'h0000_7F1C, 32'h0, 32'h0, 1'b0, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);

        // 4: back-to-back, req held; second request is presented during the first RESP cycle
        access("t4_wr", 1'b1, DEV_BASE_DEF + DEV_STRIDE_DEF + 32'({TMR_CTRL, 2'b00}),
               32'h1234_5678, 32'h0, 1'b0, 2'b10, 3, 1'b1, r1);
        access("t4_rd", 1'b0, DEV_BASE_DEF + DEV_STRIDE_DEF + 32'({TMR_CTRL, 2'b00}),
               32'h0, 32'h1234_5678, 1'b0, 2'b00, 4, 1'b0, r2);
        check("t4.ready_spacing", 32'(r2 - r1), 32'd3);
        @(negedge CLK_I);

        // 5: single-cycle IRQ on device 1
        DEV_IRQ_I = 2'b10;
        hits = 0;
        first_hit = -1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK_I);
            if (k == 1) DEV_IRQ_I = '0;
            if (HWINT == 6'b000010) begin
                hits++;
                if (first_hit < 0) first_hit = k;
            end
            check("t5.hwint_upper", 32'(HWINT[5:2]), 32'd0);
        end
        check("t5.hwint_hits", 32'(hits), 32'd1);
        check("t5.hwint_latency", 32'(first_hit), 32'd1);

        // 6: reset in the ACC cycle of a write
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_7F14;
        cpu_wdata = 32'hBAD0_0001;
        @(posedge CLK_I);
        #1;
        check("t6.we_in_acc", 32'(DEV_WE_O), 32'b10);
        RST_I = 1'b1;
        #1;
        check_outputs_zero("t6_rst");
        cpu_req = 1'b0;
        @(negedge CLK_I);
        RST_I = 1'b0;
        rdy_cnt = 0;
        repeat (4) begin
            @(negedge CLK_I);
            if (cpu_ready) rdy_cnt++;
        end
        check("t6.no_ready", 32'(rdy_cnt), 32'd0);
        access("t6_after", 1'b0, 32'h0000_7F18, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00, 3, 1'b0, r1);
        @(negedge CLK_I);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
